// File: rtl/stopwatch_pkg.sv
// Shared constants, state encoding and BCD time helpers for the stopwatch
// core and the six-digit display path.
package stopwatch_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1000000;  // 20 ms at 50 MHz
  localparam int unsigned DEFAULT_TICK_CYCLES     = 500000;   // 10 ms at 50 MHz

  localparam logic [3:0] UNITS_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX  = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } sw_state_t;

  // Field order matches the display word MM:SS:CC, most significant first.
  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_units;
    logic [3:0] sec_tens;
    logic [3:0] sec_units;
    logic [3:0] cs_tens;
    logic [3:0] cs_units;
  } bcd_time_t;

  typedef struct packed {
    logic       carry;
    logic [3:0] digit;
  } digit_step_t;

  typedef struct packed {
    logic      wrap;
    bcd_time_t value;
  } time_step_t;

  // A digit at or above its limit rolls to zero, so an out-of-range digit
  // can never survive an increment.
  function automatic digit_step_t digit_inc(input logic [3:0] digit,
                                            input logic [3:0] limit,
                                            input logic       carry_in);
    digit_step_t r;
    r.carry = 1'b0;
    r.digit = digit;
    if (carry_in) begin
      if (digit >= limit) begin
        r.digit = 4'd0;
        r.carry = 1'b1;
      end else begin
        r.digit = digit + 4'd1;
      end
    end
    return r;
  endfunction

  function automatic time_step_t time_inc(input bcd_time_t t);
    time_step_t  r;
    digit_step_t s;
    s = digit_inc(t.cs_units,  UNITS_MAX, 1'b1);    r.value.cs_units  = s.digit;
    s = digit_inc(t.cs_tens,   UNITS_MAX, s.carry); r.value.cs_tens   = s.digit;
    s = digit_inc(t.sec_units, UNITS_MAX, s.carry); r.value.sec_units = s.digit;
    s = digit_inc(t.sec_tens,  TENS_MAX,  s.carry); r.value.sec_tens  = s.digit;
    s = digit_inc(t.min_units, UNITS_MAX, s.carry); r.value.min_units = s.digit;
    s = digit_inc(t.min_tens,  TENS_MAX,  s.carry); r.value.min_tens  = s.digit;
    r.wrap = s.carry;
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_module_key_debounce.sv
// Raw push-key conditioning: 2-flop synchronizer, stable-level debouncer and
// a one-cycle pulse on each debounced press (1->0) edge.
module key_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             key_sync;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;

  assign key_sync = sync_q[1];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], key_raw};
    end
  end

  // A differing sample extends the run; any matching sample restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b1;
      cnt_q   <= '0;
      press   <= 1'b0;
    end else begin
      press <= 1'b0;
      if (key_sync == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= key_sync;
        cnt_q   <= '0;
        press   <= ~key_sync;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_module.sv
// Stopwatch core: two conditioned keys drive an IDLE/RUN/PAUSE FSM that gates
// a hundredth-second prescaler feeding a registered MM:SS:CC BCD counter.
module stopwatch_module
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned TICK_CYCLES     = DEFAULT_TICK_CYCLES
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        Key_StartStop,
  input  logic        Key_Clear,
  output logic [23:0] Hex_SixNum,
  output logic        Running,
  output logic        Wrap_Pulse
);

  localparam int unsigned PRESC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_CYCLES - 1);

  logic               start_press;
  logic               clear_press;
  sw_state_t          state_q;
  sw_state_t          state_d;
  logic [PRESC_W-1:0] presc_q;
  logic               tick;
  bcd_time_t          hex_q;
  time_step_t         step;
  logic               wrap_q;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_start (
    .clk    (CLK),
    .rst_n  (RSTn),
    .key_raw(Key_StartStop),
    .press  (start_press)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_clear (
    .clk    (CLK),
    .rst_n  (RSTn),
    .key_raw(Key_Clear),
    .press  (clear_press)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d is defaulted before the case so every path assigns it and
  // no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (clear_press)      state_d = ST_IDLE;
        else if (start_press) state_d = ST_RUN;
      end
      ST_RUN: begin
        // Clear is deliberately ignored while counting.
        if (start_press) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (clear_press)      state_d = ST_IDLE;
        else if (start_press) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tick = (state_q == ST_RUN) && (presc_q == PRESC_LAST);

  // Counting follows the registered state, so the stop cycle still counts.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      presc_q <= '0;
    end else if (state_d == ST_IDLE) begin
      presc_q <= '0;
    end else if (state_q == ST_RUN) begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
    end
  end

  assign step = time_inc(hex_q);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      hex_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= tick & step.wrap;
      if (state_d == ST_IDLE) begin
        hex_q <= '0;
      end else if (tick) begin
        hex_q <= step.value;
      end
    end
  end

  assign Hex_SixNum = hex_q;
  assign Running    = (state_q == ST_RUN);
  assign Wrap_Pulse = wrap_q;

endmodule

// File: tb/tb_stopwatch_module.sv
// Directed bench for stopwatch_module with short debounce/tick periods; all
// expected values are cycle-counted from the key-to-state latency.
module tb_stopwatch_module;

  localparam int unsigned DB = 4;
  localparam int unsigned TK = 10;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        Key_StartStop = 1'b1;
  logic        Key_Clear = 1'b1;
  logic [23:0] Hex_SixNum;
  logic        Running;
  logic        Wrap_Pulse;

  int n_compared = 0;
  int n_mismatched = 0;
  int wrap_seen = 0;

  stopwatch_module #(
    .DEBOUNCE_CYCLES(DB),
    .TICK_CYCLES    (TK)
  ) u_dut (
    .CLK          (CLK),
    .RSTn         (RSTn),
    .Key_StartStop(Key_StartStop),
    .Key_Clear    (Key_Clear),
    .Hex_SixNum   (Hex_SixNum),
    .Running      (Running),
    .Wrap_Pulse   (Wrap_Pulse)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (Wrap_Pulse === 1'b1) wrap_seen++;

  // Ends 1 ns after a rising edge.
  task automatic do_reset();
    RSTn = 1'b0;
    Key_StartStop = 1'b1;
    Key_Clear = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK) RSTn = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  // Call 1 ns after an edge. State changes on the 7th edge (C); returns at C+8 +1 ns.
  task automatic press_keys(input logic ss, input logic clr);
    Key_StartStop = !ss;
    Key_Clear = !clr;
    repeat (7) @(posedge CLK);
    #1;
    Key_StartStop = 1'b1;
    Key_Clear = 1'b1;
    repeat (8) @(posedge CLK);
    #1;
  endtask

  // Leaves the DUT paused holding 'value' with the prescaler at 5.
  task automatic preload_paused(input logic [23:0] value);
    do_reset();
    press_keys(1'b1, 1'b0);
    press_keys(1'b1, 1'b0);
    force u_dut.hex_q = value;
    #1;
    release u_dut.hex_q;
  endtask

  task automatic test_reset();
    int w0;
    do_reset();
    w0 = wrap_seen;
    n_compared++; if (Hex_SixNum !== 24'h000000) begin n_mismatched++; $display("FAIL reset_hex: got %h exp 000000", Hex_SixNum); end
    n_compared++; if (Running !== 1'b0) begin n_mismatched++; $display("FAIL reset_running: got %b exp 0", Running); end
    repeat (200) @(posedge CLK);
    #1;
    n_compared++; if (Hex_SixNum !== 24'h000000) begin n_mismatched++; $display("FAIL idle_hex: got %h exp 000000", Hex_SixNum); end
    n_compared++; if (Running !== 1'b0) begin n_mismatched++; $display("FAIL idle_running: got %b exp 0", Running); end
    n_compared++; if (wrap_seen - w0 !== 0) begin n_mismatched++; $display("FAIL idle_wrap: got %0d pulses exp 0", wrap_seen - w0); end
  endtask

  task automatic test_bounce();
    do_reset();
    repeat (2) @(posedge CLK); #1;
    Key_StartStop = 1'b0;
    repeat (2) @(posedge CLK); #1;
    Key_StartStop = 1'b1;
    repeat (2) @(posedge CLK); #1;
    Key_StartStop = 1'b0;
    repeat (6) @(posedge CLK); #1;
    n_compared++; if (Running !== 1'b0) begin n_mismatched++; $display("FAIL bounce_early: got %b exp 0", Running); end
    @(posedge CLK); #1;
    n_compared++; if (Running !== 1'b1) begin n_mismatched++; $display("FAIL bounce_run: got %b exp 1", Running); end
    repeat (3) @(posedge CLK); #1;
    Key_StartStop = 1'b1;
    repeat (996) @(posedge CLK); #1;
    n_compared++; if (Hex_SixNum !== 24'h000099) begin n_mismatched++; $display("FAIL bounce_999: got %h exp 000099", Hex_SixNum); end
    @(posedge CLK); #1;
    n_compared++; if (Hex_SixNum !== 24'h000100) begin n_mismatched++; $display("FAIL bounce_1000: got %h exp 000100", Hex_SixNum); end
    n_compared++; if (Running !== 1'b1) begin n_mismatched++; $display("FAIL bounce_release: got %b exp 1", Running); end
  endtask

  task automatic test_pause_resume();
    do_reset();
    press_keys(1'b1, 1'b0);
    n_compared++; if (Running !== 1'b1) begin n_mismatched++; $display("FAIL pr_start: got %b exp 1", Running); end
    repeat (411) @(posedge CLK); #1;
    press_keys(1'b1, 1'b0);
    n_compared++; if (Running !== 1'b0) begin n_mismatched++; $display("FAIL pr_pause: got %b exp 0", Running); end
    n_compared++; if (Hex_SixNum !== 24'h000042) begin n_mismatched++; $display("FAIL pr_count: got %h exp 000042", Hex_SixNum); end
    repeat (50) @(posedge CLK); #1;
    n_compared++; if (Hex_SixNum !== 24'h000042) begin n_mismatched++; $display("FAIL pr_hold: got %h exp 000042", Hex_SixNum); end
    press_keys(1'b1, 1'b0);
    n_compared++; if (Running !== 1'b1) begin n_mismatched++; $display("FAIL pr_resume: got %b exp 1", Running); end
    n_compared++; if (Hex_SixNum !== 24'h000043) begin n_mismatched++; $display("FAIL pr_first_tick: got %h exp 000043", Hex_SixNum); end
    repeat (5) @(posedge CLK); #1;
    n_compared++; if (Hex_SixNum !== 24'h000043) begin n_mismatched++; $display("FAIL pr_r13: got %h exp 000043", Hex_SixNum); end
    @(posedge CLK); #1;
    n_compared++; if (Hex_SixNum !== 24'h000044) begin n_mismatched++; $display("FAIL pr_r14: got %h exp 000044", Hex_SixNum); end
    press_keys(1'b1, 1'b0);
    n_compared++; if (Hex_SixNum !== 24'h000044) begin n_mismatched++; $display("FAIL pr_pause2: got %h exp 000044", Hex_SixNum); end
    press_keys(1'b0, 1'b1);
    n_compared++; if (Hex_SixNum !== 24'h000000) begin n_mismatched++; $display("FAIL pr_clear: got %h exp 000000", Hex_SixNum); end
    press_keys(1'b1, 1'b0);
    n_compared++; if (Hex_SixNum !== 24'h000000) begin n_mismatched++; $display("FAIL pr_presc_zero: got %h exp 000000", Hex_SixNum); end
    repeat (2) @(posedge CLK); #1;
    n_compared++; if (Hex_SixNum !== 24'h000001) begin n_mismatched++; $display("FAIL pr_restart_tick: got %h exp 000001", Hex_SixNum); end
  endtask

  task automatic test_carry();
    int w0;
    w0 = wrap_seen;
    preload_paused(24'h095999);
    press_keys(1'b1, 1'b0);
    n_compared++; if (Hex_SixNum !== 24'h100000) begin n_mismatched++; $display("FAIL carry_hex: got %h exp 100000", Hex_SixNum); end
    n_compared++; if (wrap_seen - w0 !== 0) begin n_mismatched++; $display("FAIL carry_wrap: got %0d pulses exp 0", wrap_seen - w0); end
  endtask

  task automatic test_wrap();
    int w0;
    w0 = wrap_seen;
    preload_paused(24'h595998);
    press_keys(1'b1, 1'b0);
    n_compared++; if (Hex_SixNum !== 24'h595999) begin n_mismatched++; $display("FAIL wrap_pre: got %h exp 595999", Hex_SixNum); end
    repeat (6) @(posedge CLK); #1;
    n_compared++; if (Wrap_Pulse !== 1'b0) begin n_mismatched++; $display("FAIL wrap_early: got %b exp 0", Wrap_Pulse); end
    @(posedge CLK); #1;
    n_compared++; if (Hex_SixNum !== 24'h000000) begin n_mismatched++; $display("FAIL wrap_hex: got %h exp 000000", Hex_SixNum); end
    n_compared++; if (Wrap_Pulse !== 1'b1) begin n_mismatched++; $display("FAIL wrap_pulse: got %b exp 1", Wrap_Pulse); end
    n_compared++; if (Running !== 1'b1) begin n_mismatched++; $display("FAIL wrap_running: got %b exp 1", Running); end
    @(posedge CLK); #1;
    n_compared++; if (Wrap_Pulse !== 1'b0) begin n_mismatched++; $display("FAIL wrap_width: got %b exp 0", Wrap_Pulse); end
    n_compared++; if (wrap_seen - w0 !== 1) begin n_mismatched++; $display("FAIL wrap_count: got %0d pulses exp 1", wrap_seen - w0); end
  endtask

  task automatic test_clear();
    do_reset();
    press_keys(1'b1, 1'b0);
    press_keys(1'b0, 1'b1);
    n_compared++; if (Running !== 1'b1) begin n_mismatched++; $display("FAIL clr_run_ignored: got %b exp 1", Running); end
    n_compared++; if (Hex_SixNum !== 24'h000002) begin n_mismatched++; $display("FAIL clr_run_count: got %h exp 000002", Hex_SixNum); end
    press_keys(1'b1, 1'b1);
    n_compared++; if (Running !== 1'b0) begin n_mismatched++; $display("FAIL both_in_run: got %b exp 0", Running); end
    n_compared++; if (Hex_SixNum !== 24'h000003) begin n_mismatched++; $display("FAIL stop_tick: got %h exp 000003", Hex_SixNum); end
    repeat (30) @(posedge CLK); #1;
    n_compared++; if (Hex_SixNum !== 24'h000003) begin n_mismatched++; $display("FAIL pause_hold: got %h exp 000003", Hex_SixNum); end
    press_keys(1'b0, 1'b1);
    n_compared++; if (Hex_SixNum !== 24'h000000) begin n_mismatched++; $display("FAIL pause_clear: got %h exp 000000", Hex_SixNum); end
    n_compared++; if (Running !== 1'b0) begin n_mismatched++; $display("FAIL pause_clear_run: got %b exp 0", Running); end
    press_keys(1'b1, 1'b1);
    n_compared++; if (Running !== 1'b0) begin n_mismatched++; $display("FAIL both_in_idle: got %b exp 0", Running); end
    press_keys(1'b1, 1'b0);
    press_keys(1'b1, 1'b0);
    n_compared++; if (Hex_SixNum !== 24'h000001) begin n_mismatched++; $display("FAIL pause2_count: got %h exp 000001", Hex_SixNum); end
    press_keys(1'b1, 1'b1);
    n_compared++; if (Running !== 1'b0) begin n_mismatched++; $display("FAIL both_in_pause: got %b exp 0", Running); end
    n_compared++; if (Hex_SixNum !== 24'h000000) begin n_mismatched++; $display("FAIL both_in_pause_hex: got %h exp 000000", Hex_SixNum); end
  endtask

  task automatic test_async_reset();
    preload_paused(24'h001230);
    press_keys(1'b1, 1'b0);
    n_compared++; if (Hex_SixNum !== 24'h001231) begin n_mismatched++; $display("FAIL ar_resume: got %h exp 001231", Hex_SixNum); end
    repeat (30) @(posedge CLK); #1;
    n_compared++; if (Hex_SixNum !== 24'h001234) begin n_mismatched++; $display("FAIL ar_count: got %h exp 001234", Hex_SixNum); end
    Key_StartStop = 1'b0;
    repeat (3) @(posedge CLK); #1;
    RSTn = 1'b0;
    #1;
    n_compared++; if (Hex_SixNum !== 24'h000000) begin n_mismatched++; $display("FAIL ar_hex: got %h exp 000000", Hex_SixNum); end
    n_compared++; if (Running !== 1'b0) begin n_mismatched++; $display("FAIL ar_running: got %b exp 0", Running); end
    n_compared++; if (Wrap_Pulse !== 1'b0) begin n_mismatched++; $display("FAIL ar_wrap: got %b exp 0", Wrap_Pulse); end
    Key_StartStop = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK) RSTn = 1'b1;
    repeat (50) @(posedge CLK); #1;
    n_compared++; if (Running !== 1'b0) begin n_mismatched++; $display("FAIL ar_idle_run: got %b exp 0", Running); end
    n_compared++; if (Hex_SixNum !== 24'h000000) begin n_mismatched++; $display("FAIL ar_idle_hex: got %h exp 000000", Hex_SixNum); end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_pause_resume();
    test_carry();
    test_wrap();
    test_clear();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
